div_issue: RTL
==============

Name: div_issue

Overview:
- EX-stage controller placed directly upstream of the iterative divider `div`.
- Accepts DIV/DIVU from the EX stage and holds operands stable for the divider's full run.
- Drives the divider start/annul handshake and stalls the pipeline until the result returns.
- Registers the 64-bit result and delivers it as a one-cycle HI/LO write.

Parameters:
DATA_W, 32, operand width (fixed to the divider's width)
TIMEOUT_CYC, 64, max BUSY cycles before the watchdog aborts the divide

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
is_div_i  in  1  EX instruction is DIV/DIVU
signed_i  in  1  1=DIV, 0=DIVU
reg1_i  in  32  dividend
reg2_i  in  32  divisor
flush_i  in  1  pipeline flush; kill the in-flight divide
div_result_i  in  64  divider result {remainder, quotient}
div_ready_i  in  1  divider result valid
div_start_o  out  1  divider start
div_annul_o  out  1  divider annul
div_signed_o  out  1  divider signed mode
div_opdata1_o  out  32  divider dividend
div_opdata2_o  out  32  divider divisor
stallreq_o  out  1  stall request to pipeline control
whilo_o  out  1  HI/LO write enable, one-cycle pulse
hi_o  out  32  remainder
lo_o  out  32  quotient
err_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst=0, async): state IDLE; hi_o, lo_o, latched operands and counters = 0.
- Reset: whilo_o, err_o = 0. All combinational outputs evaluate to 0 in IDLE with is_div_i=0.
- State machine: IDLE, BUSY, DONE, DRAIN.
- IDLE, issue condition: is_div_i=1, flush_i=0 and div_ready_i=0.
  - div_start_o=1, stallreq_o=1.
  - div_opdata*/div_signed_o pass through from reg1_i/reg2_i/signed_i.
  - Operands and signed latched at the edge; next state BUSY.
- IDLE with div_ready_i=1 (stale divider): stallreq_o=1 if is_div_i, no start; remain IDLE.
- BUSY:
  - div_start_o=1, stallreq_o=1.
  - Operand outputs come from the latches, constant for the whole divide, because the divider reads operand sign bits again at completion.
  - Watchdog counter increments each cycle.
- BUSY exits:
  - div_ready_i=1: capture hi_o=div_result_i[63:32], lo_o=div_result_i[31:0]; go DONE.
  - flush_i=1: div_annul_o=1 (combinational), start=0, stallreq=0; go DRAIN; no write. Flush has priority over ready in the same cycle.
  - Watchdog reaches TIMEOUT_CYC: same as flush, plus err_o=1 for one cycle.
- DONE:
  - Exactly one cycle: div_start_o=0, stallreq_o=0, whilo_o=1; next IDLE unconditionally.
  - The old is_div_i still visible in DONE must not re-issue.
  - start low in DONE releases the divider's end state.
- DRAIN:
  - start=0, stallreq_o=is_div_i.
  - Stay at least 2 cycles and until div_ready_i=0; then IDLE.
  - Covers divide-by-zero, whose path ignores annul and reaches its end state regardless.
- flush_i in IDLE/DONE/DRAIN: no issue in that cycle; whilo_o in DONE is not suppressed (the instruction has already retired).
- Latency with the current divider:
  - Issue in cycle T0; div_ready_i first high in T35; DONE in T36.
  - stallreq_o high T0..T35 (36 cycles).
  - The block must be correct for any ready latency ≤ TIMEOUT_CYC.
- Divide-by-zero: the divider returns 0; the block writes hi=lo=0, no error.
- No back-to-back issue: the next divide can issue no earlier than the cycle after DONE.

Decomposition:
- Add to defines.v:
  - DivIssueIdle/Busy/Done/Drain state encodings (2-bit).
  - DivStart/DivStop, DivResultReady, ZeroWord (reuse the existing entries).
  - Active-low reset-asserted constant.
- No sub-module; the watchdog is an inline counter.
- The bench instantiates div_issue with the real div module.

Test Plan:
- DIVU 100/7 → stallreq 36 cycles, then whilo_o pulse with hi_o=0x00000002, lo_o=0x0000000E; start low in DONE.
- DIV 0xFFFFFFF9 (−7) / 2, with reg1_i changed mid-run → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD. Proves the operand latches hold.
- DIVU 5/0 → hi_o=lo_o=0, whilo_o pulse, err_o=0; then a second DIVU 9/3 immediately after gives lo_o=3, hi_o=0.
- flush_i at cycle 10 of BUSY → div_annul_o=1 for one cycle, no whilo_o; DRAIN ≥2 cycles. A following DIVU 8/2 gives lo_o=4.
- Divider stub never asserts ready → err_o pulse at BUSY cycle 64, annul asserted, back to IDLE, hi/lo unchanged.
- rst low mid-BUSY (asynchronous, off the clock edge) → all outputs 0 immediately, state IDLE. After release, DIVU 1/1 gives lo_o=1.

Source files
------------

// File: rtl/div_issue_pkg.sv
// Shared encodings for the divider issue controller: FSM states and the
// handshake/reset constants that the EX-stage divider interface uses.
package div_issue_pkg;

    localparam logic        DIV_START        = 1'b1;
    localparam logic        DIV_STOP         = 1'b0;
    localparam logic        DIV_RESULT_READY = 1'b1;
    localparam logic        RST_ASSERTED     = 1'b0;
    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;

    typedef enum logic [1:0] {
        DIV_ISSUE_IDLE  = 2'b00,
        DIV_ISSUE_BUSY  = 2'b01,
        DIV_ISSUE_DONE  = 2'b10,
        DIV_ISSUE_DRAIN = 2'b11
    } div_issue_state_e;

endpackage

// File: rtl/div_issue.sv
// EX-stage controller for the iterative divider: holds operands for the whole
// run, drives start/annul, stalls the pipe and delivers the result as a HI/LO write.
module div_issue
    import div_issue_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                is_div_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   reg1_i,
    input  logic [DATA_W-1:0]   reg2_i,
    input  logic                flush_i,
    input  logic [2*DATA_W-1:0] div_result_i,
    input  logic                div_ready_i,
    output logic                div_start_o,
    output logic                div_annul_o,
    output logic                div_signed_o,
    output logic [DATA_W-1:0]   div_opdata1_o,
    output logic [DATA_W-1:0]   div_opdata2_o,
    output logic                stallreq_o,
    output logic                whilo_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    div_issue_state_e  state;
    logic [CNT_W-1:0]  cnt;
    logic              sign_q;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              whilo_q;
    logic              err_q;
    logic              issue;
    logic              wd_hit;
    logic              abort;

    // A divider still showing ready in IDLE has not released its end state yet.
    assign issue  = (state == DIV_ISSUE_IDLE) && is_div_i && !flush_i &&
                    (div_ready_i != DIV_RESULT_READY);
    assign wd_hit = (state == DIV_ISSUE_BUSY) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign abort  = (state == DIV_ISSUE_BUSY) && (flush_i || wd_hit);

    always_comb begin
        div_start_o   = DIV_STOP;
        div_annul_o   = 1'b0;
        div_signed_o  = 1'b0;
        div_opdata1_o = '0;
        div_opdata2_o = '0;
        stallreq_o    = 1'b0;
        case (state)
            DIV_ISSUE_IDLE: begin
                stallreq_o = is_div_i && !flush_i;
                if (issue) begin
                    div_start_o   = DIV_START;
                    div_signed_o  = signed_i;
                    div_opdata1_o = reg1_i;
                    div_opdata2_o = reg2_i;
                end
            end
            DIV_ISSUE_BUSY: begin
                // The divider re-reads operand signs at completion, so serve latches.
                div_signed_o  = sign_q;
                div_opdata1_o = op1_q;
                div_opdata2_o = op2_q;
                if (abort) begin
                    div_annul_o = 1'b1;
                end else begin
                    div_start_o = DIV_START;
                    stallreq_o  = 1'b1;
                end
            end
            DIV_ISSUE_DRAIN: stallreq_o = is_div_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ASSERTED) begin
            state   <= DIV_ISSUE_IDLE;
            cnt     <= '0;
            sign_q  <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            hi_q    <= DATA_W'(ZERO_WORD);
            lo_q    <= DATA_W'(ZERO_WORD);
            whilo_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            whilo_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                DIV_ISSUE_IDLE: begin
                    if (issue) begin
                        state  <= DIV_ISSUE_BUSY;
                        cnt    <= '0;
                        sign_q <= signed_i;
                        op1_q  <= reg1_i;
                        op2_q  <= reg2_i;
                    end
                end
                DIV_ISSUE_BUSY: begin
                    if (abort) begin
                        state <= DIV_ISSUE_DRAIN;
                        cnt   <= '0;
                        err_q <= wd_hit;
                    end else if (div_ready_i == DIV_RESULT_READY) begin
                        state   <= DIV_ISSUE_DONE;
                        hi_q    <= div_result_i[2*DATA_W-1:DATA_W];
                        lo_q    <= div_result_i[DATA_W-1:0];
                        whilo_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DIV_ISSUE_DONE: state <= DIV_ISSUE_IDLE;
                DIV_ISSUE_DRAIN: begin
                    // Minimum two cycles, then wait out a divider stuck in its end state.
                    if (cnt == '0) begin
                        cnt <= CNT_W'(1);
                    end else if (div_ready_i != DIV_RESULT_READY) begin
                        state <= DIV_ISSUE_IDLE;
                    end
                end
                default: state <= DIV_ISSUE_IDLE;
            endcase
        end
    end

    assign whilo_o = whilo_q;
    assign err_o   = err_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule
